// File: rtl/img_pkg.sv
// Shared image-pipeline constants and the 3x3 window packing helper.
// The MAC and FILTER weight registers use the same tap order as idx().
package img_pkg;

    localparam int AXIS_DATA_WIDTH        = 8;
    localparam int IMAGE_WIDTH_SIZE       = 512;
    localparam int IMAGE_WIDTH_LOG2_SIZE  = 9;
    localparam int IMAGE_HEIGHT_SIZE      = 512;
    localparam int IMAGE_HEIGHT_LOG2_SIZE = 9;

    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

    // Tap k = 3*r + c; r0 is the oldest line, c0 the oldest column.
    function automatic int idx(input int r, input int c);
        return WIN_DIM * r + c;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One-line pixel store: 1R1W, read-first, one write per accepted pixel.
// The read is asynchronous so it returns the old word on the write cycle.
module line_buffer #(
    parameter int DW    = 8,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster AXI4-Stream pixels in, one 3x3 window per pixel out from row 2 on.
// Left border is zero padded; rows 0-1 only prime the line buffers.
module window_gen_3x3 #(
    parameter int AXIS_DATA_WIDTH        = img_pkg::AXIS_DATA_WIDTH,
    parameter int IMAGE_WIDTH_SIZE       = img_pkg::IMAGE_WIDTH_SIZE,
    parameter int IMAGE_WIDTH_LOG2_SIZE  = img_pkg::IMAGE_WIDTH_LOG2_SIZE,
    parameter int IMAGE_HEIGHT_SIZE      = img_pkg::IMAGE_HEIGHT_SIZE,
    parameter int IMAGE_HEIGHT_LOG2_SIZE = img_pkg::IMAGE_HEIGHT_LOG2_SIZE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                         s_axis_tuser,
    input  logic                         s_axis_tlast,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [9*AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic                         frame_done,
    output logic                         sync_err
);

    import img_pkg::*;

    localparam int DW = AXIS_DATA_WIDTH;
    localparam int CW = IMAGE_WIDTH_LOG2_SIZE;
    localparam int RW = IMAGE_HEIGHT_LOG2_SIZE;

    localparam logic [CW-1:0] COL_MAX   = CW'(IMAGE_WIDTH_SIZE - 1);
    localparam logic [RW-1:0] ROW_MAX   = RW'(IMAGE_HEIGHT_SIZE - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(2);

    logic          accept;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic          err_nxt;
    logic          col_last;
    logic          row_last;
    logic          row_ok;
    logic [DW-1:0] lb0_q;
    logic [DW-1:0] lb1_q;

    logic [DW-1:0] win [WIN_DIM][WIN_DIM];
    logic [DW-1:0] nxt [WIN_DIM][WIN_DIM];
    logic [9*DW-1:0] win_flat;

    assign s_axis_tready = enable & (~m_axis_tvalid | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    assign col_last = (col == COL_MAX);
    assign row_last = (row == ROW_MAX);
    assign row_ok   = (row >= ROW_FIRST);

    line_buffer #(
        .DW    (DW),
        .DEPTH (IMAGE_WIDTH_SIZE),
        .AW    (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (accept & ~rst),
        .addr  (col),
        .wdata (s_axis_tdata),
        .rdata (lb0_q)
    );

    line_buffer #(
        .DW    (DW),
        .DEPTH (IMAGE_WIDTH_SIZE),
        .AW    (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (accept & ~rst),
        .addr  (col),
        .wdata (lb0_q),
        .rdata (lb1_q)
    );

    // Window after this pixel: columns shift left, new column on the right.
    always_comb begin
        for (int r = 0; r < WIN_DIM; r++) begin
            nxt[r][0] = win[r][1];
            nxt[r][1] = win[r][2];
        end
        nxt[0][2] = lb1_q;
        nxt[1][2] = lb0_q;
        nxt[2][2] = s_axis_tdata;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < WIN_DIM; r++) begin
            for (int c = 0; c < WIN_DIM; c++) begin
                if (int'(col) + c >= 2) begin
                    win_flat[DW*idx(r, c) +: DW] = nxt[r][c];
                end
            end
        end
    end

    // Position tracking; EOL and tlast resynchronise the counters.
    always_comb begin
        col_nxt = col + 1'b1;
        row_nxt = row;
        err_nxt = 1'b0;
        if (s_axis_tlast) begin
            col_nxt = '0;
            row_nxt = '0;
            err_nxt = ~(row_last & col_last & s_axis_tuser);
        end else if (s_axis_tuser | col_last) begin
            col_nxt = '0;
            row_nxt = row_last ? '0 : row + 1'b1;
            err_nxt = ~(s_axis_tuser & col_last);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col           <= '0;
            row           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            frame_done    <= 1'b0;
            sync_err      <= 1'b0;
            for (int r = 0; r < WIN_DIM; r++) begin
                for (int c = 0; c < WIN_DIM; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else begin
            frame_done <= m_axis_tvalid & m_axis_tready & m_axis_tlast;
            if (accept) begin
                col           <= col_nxt;
                row           <= row_nxt;
                win           <= nxt;
                sync_err      <= sync_err | err_nxt;
                m_axis_tvalid <= row_ok;
                if (row_ok) begin
                    m_axis_tdata <= win_flat;
                    m_axis_tuser <= s_axis_tuser;
                    m_axis_tlast <= s_axis_tlast;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3 on a 4x4 image.
// A column-history model predicts windows; a monitor pops and compares.
module tb_window_gen_3x3;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int WL = 2;
    localparam int H  = 4;
    localparam int HL = 2;

    localparam logic [9*DW-1:0] FIRST_WIN = 72'h20_0000_10_0000_00_0000;
    localparam logic [9*DW-1:0] R2C2_WIN  = 72'h22_21_20_12_11_10_02_01_00;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic s_tvalid;
    logic s_tready;
    logic [DW-1:0] s_tdata;
    logic s_tuser;
    logic s_tlast;
    logic m_tvalid;
    logic m_tready = 1'b1;
    logic [9*DW-1:0] m_tdata;
    logic m_tuser;
    logic m_tlast;
    logic frame_done;
    logic sync_err;

    always #5 clk = ~clk;

    window_gen_3x3 #(
        .AXIS_DATA_WIDTH        (DW),
        .IMAGE_WIDTH_SIZE       (W),
        .IMAGE_WIDTH_LOG2_SIZE  (WL),
        .IMAGE_HEIGHT_SIZE      (H),
        .IMAGE_HEIGHT_LOG2_SIZE (HL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tuser  (s_tuser),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tuser  (m_tuser),
        .m_axis_tlast  (m_tlast),
        .frame_done    (frame_done),
        .sync_err      (sync_err)
    );

    typedef struct packed {
        logic [9*DW-1:0] data;
        logic            user;
        logic            last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int failures = 0;
    int ready_mode = 0;
    int n_win = 0;
    int exp_cnt = 0;
    int fd_cnt = 0;
    bit pat = 0;

    // Reference: each column remembers its last two pixels; the current
    // row keeps the {oldest, middle, new} column seen at each position.
    logic [DW-1:0] hist0 [W];
    logic [DW-1:0] hist1 [W];
    logic [DW-1:0] colv [W][3];
    int mcol = 0;
    int mrow = 0;
    logic merr = 1'b0;

    task automatic chk(input string name, input logic [9*DW-1:0] act,
                       input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] pix, input logic u,
                                input logic l);
        exp_t e;
        int cc;
        colv[mcol][0] = hist1[mcol];
        colv[mcol][1] = hist0[mcol];
        colv[mcol][2] = pix;
        e.data = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cc = mcol - 2 + c;
                if (cc >= 0) e.data[DW*(3*r+c) +: DW] = colv[cc][r];
            end
        end
        e.user = u;
        e.last = l;
        if (mrow >= 2) begin
            exp_q.push_back(e);
            exp_cnt++;
        end
        hist1[mcol] = hist0[mcol];
        hist0[mcol] = pix;
        if (l) begin
            if (!(mrow == H-1 && mcol == W-1 && u)) merr = 1'b1;
            mcol = 0;
            mrow = 0;
        end else if (u || mcol == W-1) begin
            if (!(u && mcol == W-1)) merr = 1'b1;
            mcol = 0;
            mrow = (mrow + 1) % H;
        end else begin
            mcol++;
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: m_tready = 1'b1;
            1: m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
    end

    logic [9*DW-1:0] held;
    bit stalled = 0;
    bit fd_pend = 0;

    always @(negedge clk) begin
        if (rst) begin
            stalled = 0;
            fd_pend = 0;
        end else begin
            if (fd_pend || frame_done)
                chk("frame_done", 72'(frame_done), 72'(fd_pend));
            if (frame_done) fd_cnt++;
            fd_pend = 0;
            if (stalled) begin
                chk("hold_valid", 72'(m_tvalid), 72'd1);
                chk("hold_data", m_tdata, held);
            end
            stalled = 0;
            if (m_tvalid && !m_tready) begin
                chk("s_tready_stall", 72'(s_tready), 72'd0);
                stalled = 1;
                held = m_tdata;
            end
            if (m_tvalid && m_tready) begin
                n_win++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window: got %h expected none",
                             m_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("win_data", m_tdata, mon_e.data);
                    chk("win_user", 72'(m_tuser), 72'(mon_e.user));
                    chk("win_last", 72'(m_tlast), 72'(mon_e.last));
                end
                if (pat && n_win == 1) chk("first_window", m_tdata, FIRST_WIN);
                if (pat && n_win == 3) chk("r2c2_window", m_tdata, R2C2_WIN);
                fd_pend = m_tlast;
            end
        end
    end

    task automatic send(input logic [DW-1:0] pix, input logic u,
                        input logic l);
        int budget = 0;
        s_tvalid = 1'b1;
        s_tdata  = pix;
        s_tuser  = u;
        s_tlast  = l;
        @(negedge clk);
        while (!s_tready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!s_tready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got tready=0 expected 1");
            s_tvalid = 1'b0;
        end else begin
            @(posedge clk);
            model_accept(pix, u, l);
            #1;
            s_tvalid = 1'b0;
        end
    endtask

    task automatic check_reset();
        chk("rst_tvalid", 72'(m_tvalid), 72'd0);
        chk("rst_tdata", m_tdata, 72'd0);
        chk("rst_tuser", 72'(m_tuser), 72'd0);
        chk("rst_tlast", 72'(m_tlast), 72'd0);
        chk("rst_frame_done", 72'(frame_done), 72'd0);
        chk("rst_sync_err", 72'(sync_err), 72'd0);
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        rst = 1'b1;
        s_tvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset();
        exp_q.delete();
        mcol = 0;
        mrow = 0;
        merr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while (exp_q.size() != 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("drain_left", 72'(exp_q.size()), 72'd0);
    endtask

    task automatic start(input bit p);
        pat = p;
        n_win = 0;
        exp_cnt = 0;
        fd_cnt = 0;
    endtask

    task automatic run_frame(input bit rnd, input int gap, input int drop_at,
                             input int rst_at, input int skip_at,
                             input bit inject);
        for (int i = 0; i < W*H; i++) begin
            int r;
            int c;
            logic [DW-1:0] p;
            logic u;
            logic l;
            r = i / W;
            c = i % W;
            p = rnd ? DW'($urandom) : DW'(16*r + c);
            u = (c == W-1) || (i + 1 == skip_at);
            if (inject && $urandom_range(0, 7) == 0) u = ~u;
            l = (i == W*H-1);
            if (i == rst_at) begin
                do_reset();
                return;
            end
            if (i != skip_at) begin
                if (i == drop_at) begin
                    s_tvalid = 1'b1;
                    enable = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        chk("tready_disabled", 72'(s_tready), 72'd0);
                    end
                    @(posedge clk);
                    #1;
                    enable = 1'b1;
                end
                send(p, u, l);
                repeat ($urandom_range(0, gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic frame_counts(input int wins, input int fds);
        chk("win_count", 72'(n_win), 72'(wins));
        chk("model_count", 72'(exp_cnt), 72'(wins));
        chk("frame_done_count", 72'(fd_cnt), 72'(fds));
    endtask

    initial begin
        for (int i = 0; i < W; i++) begin
            hist0[i] = '0;
            hist1[i] = '0;
        end
        rst = 1'b1;
        enable = 1'b1;
        s_tvalid = 1'b0;
        s_tdata = '0;
        s_tuser = 1'b0;
        s_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        start(1);
        run_frame(0, 0, -1, -1, -1, 0);
        drain();
        frame_counts(8, 1);
        chk("s1_sync_err", 72'(sync_err), 72'd0);

        ready_mode = 1;
        start(1);
        run_frame(0, 3, -1, -1, -1, 0);
        drain();
        frame_counts(8, 1);

        ready_mode = 0;
        start(1);
        run_frame(0, 0, -1, -1, 7, 0);
        drain();
        frame_counts(8, 1);
        chk("s3_sync_err", 72'(sync_err), 72'd1);
        do_reset();

        ready_mode = 1;
        start(1);
        run_frame(0, 1, 9, -1, -1, 0);
        drain();
        frame_counts(8, 1);

        ready_mode = 0;
        start(0);
        run_frame(0, 0, -1, 13, -1, 0);
        start(1);
        run_frame(0, 0, -1, -1, -1, 0);
        drain();
        frame_counts(8, 1);
        chk("s5_sync_err", 72'(sync_err), 72'd0);

        ready_mode = 2;
        for (int f = 0; f < 6; f++) begin
            start(0);
            run_frame(1, 2, (f == 2) ? 5 : -1, -1, -1, 0);
            drain();
            frame_counts(8, 1);
        end
        for (int f = 0; f < 4; f++) begin
            start(0);
            run_frame(1, 1, -1, -1, -1, 1);
            drain();
            chk("inj_win_count", 72'(n_win), 72'(exp_cnt));
            chk("inj_sync_err", 72'(sync_err), 72'(merr));
            do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
